// File: rtl/pad_frame_streamer_if.sv
// Row stream bundle between the line fetcher, the pad streamer and the conv line buffer.
// The streamer takes the slave modport; the upstream/downstream side takes master.
interface pad_frame_streamer_if #(
  parameter int W  = 416,
  parameter int PB = 8,
  parameter int CH = 3,
  parameter int P  = 1
);
  localparam int IW = CH * W * PB;
  localparam int OW = CH * (W + 2 * P) * PB;

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_row;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_row;
  logic          out_first;
  logic          out_last;

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_first, out_last
  );

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_first, out_last
  );
endinterface

// File: rtl/pad_frame_streamer.sv
// Wraps a W x H frame in a P-pixel border, streaming one padded row per handshake.
// Optional macro PAD_VALUE_EN: adds pad_value_i, latched at start; otherwise zero padding.
//
// state | meaning
// IDLE  | waiting for start
// TOP   | emitting the P top pad rows
// BODY  | forwarding H input rows with side borders
// BOT   | emitting the P bottom pad rows, then waiting for the last handshake
module pad_frame_streamer #(
  parameter int W  = 416,
  parameter int H  = 416,
  parameter int PB = 8,
  parameter int CH = 3,
  parameter int P  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
`ifdef PAD_VALUE_EN
  input  logic [PB-1:0]        pad_value_i,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  pad_frame_streamer_if.slave  s
);

  localparam int OWP   = W + 2 * P;
  localparam int NROWS = H + 2 * P;
  localparam int RW    = $clog2(NROWS);
  localparam int OW    = CH * OWP * PB;

  generate
    if (P < 1 || P > 8) begin : g_bad_pad
      $error("pad_frame_streamer: P must be in 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, TOP, BODY, BOT} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic            out_valid_q, out_valid_d;
  logic [OW-1:0]   out_row_q, out_row_d;
  logic            out_first_q, out_first_d;
  logic            out_last_q, out_last_d;
  logic [OW-1:0]   row_data;
  logic [PB-1:0]   pad_px;
  logic            out_free, row_avail, load, done, start_ok;

`ifdef PAD_VALUE_EN
  logic [PB-1:0]   pad_q, pad_d;
  assign pad_px = pad_q;
`else
  assign pad_px = '0;
`endif

  assign out_free = !out_valid_q || s.out_ready;
  // The final pad row is on the output once out_last_q is set; nothing more to load.
  assign done     = (state_q == BOT) && out_valid_q && out_last_q && s.out_ready;
  assign start_ok = start_i && ((state_q == IDLE) || done);
  assign load     = out_free && row_avail;

  always_comb begin
    row_avail = 1'b0;
    unique case (state_q)
      TOP:     row_avail = 1'b1;
      BODY:    row_avail = s.in_valid;
      BOT:     row_avail = !(out_valid_q && out_last_q);
      default: row_avail = 1'b0;
    endcase
  end

  always_comb begin
    row_data = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < OWP; k++) begin
        row_data[(c*OWP + k)*PB +: PB] = pad_px;
      end
    end
    if (state_q == BODY) begin
      for (int c = 0; c < CH; c++) begin
        for (int j = 0; j < W; j++) begin
          row_data[(c*OWP + j + P)*PB +: PB] = s.in_row[(c*W + j)*PB +: PB];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
`ifdef PAD_VALUE_EN
    pad_d       = pad_q;
    if (start_ok) pad_d = pad_value_i;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = TOP;
      end
      TOP: begin
        if (load) begin
          row_d = row_q + RW'(1);
          if (row_q == RW'(P - 1)) state_d = BODY;
        end
      end
      BODY: begin
        if (load) begin
          row_d = row_q + RW'(1);
          if (row_q == RW'(P + H - 1)) state_d = BOT;
        end
      end
      BOT: begin
        if (load) row_d = (row_q == RW'(NROWS - 1)) ? '0 : row_q + RW'(1);
        if (done) state_d = start_i ? TOP : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_row_d   = row_data;
      out_first_d = (row_q == '0);
      out_last_d  = (row_q == RW'(NROWS - 1));
    end else if (s.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef PAD_VALUE_EN
      pad_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
`ifdef PAD_VALUE_EN
      pad_q       <= pad_d;
`endif
    end
  end

  assign s.in_ready  = (state_q == BODY) && out_free;
  assign s.out_valid = out_valid_q;
  assign s.out_row   = out_row_q;
  assign s.out_first = out_first_q;
  assign s.out_last  = out_last_q;
  assign busy_o      = (state_q != IDLE) || out_valid_q;
  assign done_o      = done;

endmodule
